// File: rtl/wb_host_bridge.sv
// Single-outstanding bridge from a valid/ready command/response port onto a
// Wishbone classic master, with an abort after TIMEOUT unacknowledged cycles.
module wb_host_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       cyc;
  logic       to_hit;

  assign cmd_ready = (state == IDLE);
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign to_hit    = (cnt == TO_LAST);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; ack beats timeout when both land on the same edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = BUS;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUS: begin
        if (wbm_ack_i || to_hit) begin
          state_nxt = RESP;
        end else begin
          state_nxt = BUS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-side registers, timeout counter and response registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt       <= 8'd0;
      cyc       <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            cnt       <= 8'd0;
            cyc       <= 1'b1;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            cyc       <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (to_hit) begin
            cyc       <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          // Response fields return to their idle values once consumed
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          cyc       <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge: a scoreboard queue holds expected
// responses pushed at command issue and popped when rsp_valid appears.
module tb_wb_host_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic [3:0]  cmd_sel = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'd0;
  logic        wbm_ack_i = 1'b0;

  int total = 0;
  int bad = 0;
  logic [32:0] sb[$];

  wb_host_bridge #(.TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ack_at: BUS cycle (1-based) in which ack is driven, 0 = never.
  // stall: cycles rsp_ready is held low while stray acks and commands are driven.
  task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdat,
                        input int stall);
    logic        err_e;
    int          cyc_e;
    int          n;
    logic [32:0] exp;
    err_e = (ack_at < 1 || ack_at > TO);
    cyc_e = err_e ? TO : ack_at;
    sb.push_back({err_e, (!err_e && !we) ? rdat : 32'h0});
    check("ready_idle", cmd_ready, 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;
    n = 0;
    while (wbm_cyc_o === 1'b1 && n < 40) begin
      n++;
      check("stb", wbm_stb_o, 32'd1);
      check("we", wbm_we_o, we);
      check("adr", wbm_adr_o, adr);
      check("dat_o", wbm_dat_o, dat);
      check("sel", wbm_sel_o, sel);
      check("ready_bus", cmd_ready, 32'd0);
      if (n == ack_at) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rdat;
      end
      tick();
      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom;
    end
    check("stb_cycles", n, cyc_e);
    check("rsp_valid", rsp_valid, 32'd1);
    check("sb_level", sb.size(), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 33'h0;
    check("rsp_dat", rsp_dat, exp[31:0]);
    check("rsp_err", rsp_err, exp[32]);
    for (int i = 0; i < stall; i++) begin
      wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
      cmd_valid = 1'b1; cmd_adr = $urandom;
      tick();
      check("hold_valid", rsp_valid, 32'd1);
      check("hold_dat", rsp_dat, exp[31:0]);
      check("hold_err", rsp_err, exp[32]);
      check("hold_ready", cmd_ready, 32'd0);
      check("hold_cyc", wbm_cyc_o, 32'd0);
    end
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_drop", rsp_valid, 32'd0);
    check("rsp_dat_clr", rsp_dat, 32'd0);
    check("ready_back", cmd_ready, 32'd1);
    check("no_early_accept", wbm_cyc_o, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_ready", cmd_ready, 32'd1);
    check("rst_cyc", wbm_cyc_o, 32'd0);
    check("rst_stb", wbm_stb_o, 32'd0);
    check("rst_we", wbm_we_o, 32'd0);
    check("rst_sel", wbm_sel_o, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_rvalid", rsp_valid, 32'd0);
    check("rst_rdat", rsp_dat, 32'd0);
    check("rst_rerr", rsp_err, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // write, ack in third cycle
    do_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 3, 32'hAAAA_5555, 0);
    // read, ack in first cycle -> minimum latency
    do_cmd(1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 1, 32'h1234_5678, 0);
    // timeout, never acked
    do_cmd(1'b0, 32'h3000_0010, 32'h0000_0000, 4'h3, 0, 32'h0, 0);
    // ack on the timeout edge wins
    do_cmd(1'b0, 32'h3000_0020, 32'h0000_0000, 4'hC, TO, 32'hCAFE_F00D, 0);
    // write timeout
    do_cmd(1'b1, 32'h3000_0030, 32'h0BAD_CAFE, 4'h1, 0, 32'h0, 0);
    // backpressure with stray acks and pending command
    do_cmd(1'b0, 32'h3000_0040, 32'h0000_0000, 4'hF, 2, 32'h8765_4321, 5);

    // reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0050; cmd_dat = 32'h5A5A_A5A5; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    check("mid_cyc", wbm_cyc_o, 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cyc", wbm_cyc_o, 32'd0);
    check("mid_rst_stb", wbm_stb_o, 32'd0);
    check("mid_rst_adr", wbm_adr_o, 32'd0);
    check("mid_rst_dat", wbm_dat_o, 32'd0);
    check("mid_rst_we", wbm_we_o, 32'd0);
    check("mid_rst_rvalid", rsp_valid, 32'd0);
    check("mid_rst_ready", cmd_ready, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wbm_ack_i = 1'b1;
      wbm_dat_i = $urandom;
      tick();
      check("post_rst_rvalid", rsp_valid, 32'd0);
      check("post_rst_cyc", wbm_cyc_o, 32'd0);
    end
    wbm_ack_i = 1'b0;

    // first command after reset accepted on the first edge
    do_cmd(1'b0, 32'h3000_0060, 32'h0000_0000, 4'h6, 4, 32'h0F0F_F0F0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_host_bridge.md
WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max BUS-state cycles without wbm_ack_i before abort (legal 2..255).
REQ-002 wb_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command request from local logic.
REQ-005 cmd_ready  output  1  bridge can accept a command.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_adr  input  32  byte address.
REQ-008 cmd_dat  input  32  write data.
REQ-009 cmd_sel  input  4  byte lane selects.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  local logic accepts response.
REQ-012 rsp_dat  output  32  read data; 0 for writes and aborts.
REQ-013 rsp_err  output  1  1 = transaction aborted by timeout.
REQ-014 wbm_cyc_o, wbm_stb_o  output  1 each  Wishbone classic cycle/strobe.
REQ-015 wbm_we_o  output  1; wbm_sel_o  output  4; wbm_adr_o  output  32; wbm_dat_o  output  32  registered copies of the accepted command.
REQ-016 wbm_dat_i  input  32  read data from responder; wbm_ack_i  input  1  responder acknowledge.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-018 IDLE: cmd_ready = 1; all other outputs hold reset values except wbm_* address/data/sel/we, which may hold last values.
REQ-019 cmd_ready SHALL be a combinational decode of state IDLE only; 0 in BUS and RESP.
REQ-020 Accept = cmd_valid & cmd_ready at an edge: latch we/adr/dat/sel into wbm_* registers, clear timeout counter, enter BUS; wbm_cyc_o = wbm_stb_o = 1 from that edge.
REQ-021 In BUS all wbm_* outputs SHALL remain stable until the cycle terminates; cmd_* inputs ignored.
REQ-022 BUS, wbm_ack_i = 1 at an edge: deassert wbm_cyc_o/wbm_stb_o at that edge, rsp_dat <= wbm_dat_i if read else 0, rsp_err <= 0, rsp_valid <= 1, enter RESP.
REQ-023 BUS, no ack: counter increments by 1 per edge; when counter == TIMEOUT-1 with no ack at that edge, deassert cyc/stb, rsp_dat <= 0, rsp_err <= 1, rsp_valid <= 1, enter RESP (abort after exactly TIMEOUT cycles with stb high).
REQ-024 Ack and timeout at same edge: ack SHALL win (normal completion, rsp_err = 0).
REQ-025 Counter width 8 bits; SHALL not wrap while in BUS.
REQ-026 Minimum latency: ack in first BUS cycle -> rsp_valid high one cycle after accept edge.
REQ-027 RESP: rsp_valid, rsp_dat, rsp_err held stable until rsp_valid & rsp_ready at an edge, then rsp_valid <= 0 and enter IDLE; new command accepted no earlier than the following edge.
REQ-028 wbm_ack_i in IDLE or RESP SHALL be ignored (no state or output change).
REQ-029 Exactly one Wishbone cycle per accepted command; no pipelining, no bursts, one outstanding transaction.

Reset
REQ-030 wb_rst_i = 1 SHALL immediately (no clock) force state IDLE, counter 0, wbm_cyc_o = wbm_stb_o = wbm_we_o = 0, wbm_sel_o = 0, wbm_adr_o = wbm_dat_o = 0, rsp_valid = 0, rsp_dat = 0, rsp_err = 0.
REQ-031 Reset asserted mid-BUS SHALL drop cyc/stb asynchronously and discard the transaction; no response is produced.
REQ-032 After reset deassertion, cmd_ready = 1 and the first command is accepted at the first edge with cmd_valid = 1.

Verification
REQ-033 Write: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, ack after 3 cycles -> wbm_* match for 3 cycles with cyc/stb high, rsp_valid with rsp_dat=0, rsp_err=0.
REQ-034 Read: cmd we=0 adr=0x3000_0000, ack in first cycle with wbm_dat_i=0x1234_5678 -> rsp_valid one cycle after accept, rsp_dat=0x1234_5678.
REQ-035 Timeout: TIMEOUT=8, never ack -> cyc/stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0.
REQ-036 Ack at the timeout edge (TIMEOUT=8, ack in 8th cycle) -> rsp_err=0, read data captured.
REQ-037 Backpressure: rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, stray wbm_ack_i ignored; new cmd accepted only after response handshake.
REQ-038 Reset asserted mid-BUS between edges -> cyc/stb and all outputs 0 before next edge; no rsp_valid after release.
